cpu_state_dumper: RTL

Synthesizable, parametrised state-dump engine for the single/multi-cycle CPU cores. On a PC-match trigger or a manual start, it walks the register file, the data memory, or both, through their read ports. Each word is streamed out as one beat on a valid/ready channel. It replaces bench-only dump loops, so dumps also work on FPGA and under back-pressure.

---
 rtl/cpu_state_dumper_if.sv | 27 ++
 rtl/cpu_state_dumper.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/cpu_state_dumper_if.sv
// rtl/cpu_state_dumper_if.sv - dump beat stream between the state dumper and its consumer
interface cpu_state_dumper_if #(
  parameter int DATA_W = 32,
  parameter int IDX_W  = 8
);
  logic              o_dump_valid;
  logic              o_dump_src;
  logic [IDX_W-1:0]  o_dump_idx;
  logic [DATA_W-1:0] o_dump_dat;
  logic              i_dump_ready;

  modport master (
    output o_dump_valid,
    output o_dump_src,
    output o_dump_idx,
    output o_dump_dat,
    input  i_dump_ready
  );

  modport slave (
    input  o_dump_valid,
    input  o_dump_src,
    input  o_dump_idx,
    input  o_dump_dat,
    output i_dump_ready
  );
endinterface

// File: rtl/cpu_state_dumper.sv
// rtl/cpu_state_dumper.sv - walks RF and/or DM read ports on PC-match or start, streaming one beat per word
module cpu_state_dumper #(
  parameter int              DATA_W   = 32,
  parameter int              PC_W     = 32,
  parameter int              RF_DEPTH = 32,
  parameter int              RF_AW    = 5,
  parameter int              DM_WORDS = 64,
  parameter int              DM_AW    = 6,
  parameter int              IDX_W    = 8,
  parameter logic [PC_W-1:0] TRIG_PC  = '0
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic [PC_W-1:0]     i_pc,
  input  logic                i_pc_valid,
  input  logic                i_start,
  input  logic [1:0]          i_mode,
  output logic                o_rf_re,
  output logic [RF_AW-1:0]    o_rf_addr,
  input  logic [DATA_W-1:0]   i_rf_dat,
  output logic                o_dm_re,
  output logic [DM_AW-1:0]    o_dm_addr,
  input  logic [DATA_W-1:0]   i_dm_dat,
  cpu_state_dumper_if.master  dump,
  output logic                o_busy,
  output logic                o_done,
  output logic [7:0]          o_dump_cnt
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_CAP,
    S_SEND,
    S_FIN
  } state_t;

  state_t           state;
  logic             armed;
  logic             mode_dm_q;
  logic             src_q;
  logic [IDX_W-1:0] idx_q;

  logic             pc_hit;
  logic             trig;
  logic             last_entry;
  logic [IDX_W-1:0] idx_inc;

  assign pc_hit  = armed & i_pc_valid & (i_pc == TRIG_PC);
  assign trig    = i_start | pc_hit;
  assign idx_inc = idx_q + IDX_W'(1);

  // Stop on the real depth, so non-power-of-two tables end at the right entry
  assign last_entry = src_q ? (idx_q == IDX_W'(DM_WORDS - 1))
                            : (idx_q == IDX_W'(RF_DEPTH - 1));

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state             <= S_IDLE;
      armed             <= 1'b1;
      mode_dm_q         <= 1'b0;
      src_q             <= 1'b0;
      idx_q             <= '0;
      o_rf_re           <= 1'b0;
      o_rf_addr         <= '0;
      o_dm_re           <= 1'b0;
      o_dm_addr         <= '0;
      dump.o_dump_valid <= 1'b0;
      dump.o_dump_src   <= 1'b0;
      dump.o_dump_idx   <= '0;
      dump.o_dump_dat   <= '0;
      o_busy            <= 1'b0;
      o_done            <= 1'b0;
      o_dump_cnt        <= '0;
    end else begin
      o_rf_re <= 1'b0;
      o_dm_re <= 1'b0;
      o_done  <= 1'b0;

      // Re-arm only once the core retires somewhere else, so a loop at TRIG_PC dumps once
      if (i_pc_valid && (i_pc != TRIG_PC)) begin
        armed <= 1'b1;
      end

      case (state)
        S_IDLE: begin
          if (trig) begin
            mode_dm_q <= i_mode[1];
            src_q     <= ~i_mode[0];
            idx_q     <= '0;
            o_busy    <= 1'b1;
            if (pc_hit) begin
              armed <= 1'b0;
            end
            if (i_mode == 2'b00) begin
              state <= S_FIN;
            end else begin
              o_rf_re   <= i_mode[0];
              o_dm_re   <= ~i_mode[0];
              o_rf_addr <= '0;
              o_dm_addr <= '0;
              state     <= S_REQ;
            end
          end
        end

        S_REQ: begin
          state <= S_CAP;
        end

        S_CAP: begin
          dump.o_dump_dat   <= src_q ? i_dm_dat : i_rf_dat;
          dump.o_dump_src   <= src_q;
          dump.o_dump_idx   <= idx_q;
          dump.o_dump_valid <= 1'b1;
          state             <= S_SEND;
        end

        S_SEND: begin
          if (dump.i_dump_ready) begin
            dump.o_dump_valid <= 1'b0;
            if (!last_entry) begin
              idx_q <= idx_inc;
              if (src_q) begin
                o_dm_re   <= 1'b1;
                o_dm_addr <= idx_inc[DM_AW-1:0];
              end else begin
                o_rf_re   <= 1'b1;
                o_rf_addr <= idx_inc[RF_AW-1:0];
              end
              state <= S_REQ;
            end else if (!src_q && mode_dm_q) begin
              src_q     <= 1'b1;
              idx_q     <= '0;
              o_dm_re   <= 1'b1;
              o_dm_addr <= '0;
              state     <= S_REQ;
            end else begin
              state <= S_FIN;
            end
          end
        end

        S_FIN: begin
          o_done <= 1'b1;
          o_busy <= 1'b0;
          if (o_dump_cnt != 8'hFF) begin
            o_dump_cnt <= o_dump_cnt + 8'd1;
          end
          state <= S_IDLE;
        end

        default: begin
          state  <= S_IDLE;
          o_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule
